// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add (MUL) or restoring-subtract (DIV) step per cycle, then a sign-fix cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO and divide-by-zero complete here
  // MUL   | one shift-add step per cycle, cnt counts down to 0
  // DIV   | one restoring-subtract step per cycle, cnt counts down to 0
  // FIX   | sign correction, hi/lo written on exit
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t state, state_nx;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     div_t, div_diff;
  logic [2*WIDTH-1:0] div_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_mag, r_mag, q_fix, r_fix;

  assign busy = (state != S_IDLE);

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    // acc = {upper partial sum, remaining multiplier bits}
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx    = {mul_sum, acc[WIDTH-1:1]};

    // acc = {remainder, quotient}; rem < divisor keeps the difference within WIDTH bits
    div_t     = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_t - {1'b0, opnd};
    div_nx    = (div_t >= {1'b0, opnd}) ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                        : {div_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    prod_fix  = neg_q ? -acc : acc;
    q_mag     = acc[WIDTH-1:0];
    r_mag     = acc[2*WIDTH-1:WIDTH];
    q_fix     = neg_q ? -q_mag : q_mag;
    r_fix     = neg_r ? -r_mag : r_mag;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: state_nx = S_MUL;
            OP_DIV, OP_DIVU:   state_nx = (b != '0) ? S_DIV : S_IDLE;
            default:           state_nx = S_IDLE;
          endcase
        end
      end
      S_MUL:   if (cnt == '0) state_nx = S_FIX;
      S_DIV:   if (cnt == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      dbz   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc    <= {{WIDTH{1'b0}}, b_mag};
                opnd   <= a_mag;
                cnt    <= CW'(WIDTH - 1);
                is_div <= 1'b0;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                  hi   <= a;
                  lo   <= '1;
                  done <= 1'b1;
                  dbz  <= 1'b1;
                end else begin
                  acc    <= {{WIDTH{1'b0}}, a_mag};
                  opnd   <= b_mag;
                  cnt    <= CW'(WIDTH - 1);
                  is_div <= 1'b1;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                end
              end
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc <= mul_nx;
          cnt <= cnt - CW'(1);
        end
        S_DIV: begin
          acc <= div_nx;
          cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, divide-by-zero, busy-ignore and reset abort.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // drive a one-cycle start; returns in cycle k+1 (1 ns after edge k)
  task automatic launch(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // advance until done; n counts cycles since edge k, capped so a missing done shows as wrong latency
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    step(2);
    n_cmp++; if ({busy, done, dbz} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {busy, done, dbz}); end
    n_cmp++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_mult;
    int n;
    launch(3'b000, 32'hFFFFFFFD, 32'h00000005);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_k1 got %b want 1", busy); end
    n_cmp++; if (hi !== '0 || lo !== '0) begin n_err++; $display("FAIL mult_no_intermediate got %h_%h want 0_0", hi, lo); end
    wait_done(1, n);
    n_cmp++; if (n !== 34) begin n_err++; $display("FAIL mult_latency got %0d want 34", n); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_done got %b want 0", busy); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL mult_dbz got %b want 0", dbz); end
    step(1);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse got %b want 0", done); end
  endtask

  task automatic test_mult_full;
    int n;
    launch(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, n);
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL multu_ff got %h_%h want fffffffe_00000001", hi, lo); end
    step(1);
    launch(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, n);
    n_cmp++; if (n !== 34) begin n_err++; $display("FAIL mult_ff_latency got %0d want 34", n); end
    n_cmp++; if ({hi, lo} !== 64'h00000000_00000001) begin n_err++; $display("FAIL mult_ff got %h_%h want 00000000_00000001", hi, lo); end
    step(1);
  endtask

  task automatic test_div;
    int n;
    launch(3'b010, 32'hFFFFFFF9, 32'h00000002);
    wait_done(1, n);
    n_cmp++; if (n !== 34) begin n_err++; $display("FAIL div_latency got %0d want 34", n); end
    n_cmp++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg7_2 got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL div_dbz got %b want 0", dbz); end
    step(1);
    launch(3'b011, 32'd7, 32'd2);
    wait_done(1, n);
    n_cmp++; if (lo !== 32'd3 || hi !== 32'd1) begin n_err++; $display("FAIL divu_7_2 got hi=%h lo=%h want hi=1 lo=3", hi, lo); end
    step(1);
    launch(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1, n);
    n_cmp++; if (lo !== 32'h80000000 || hi !== 32'h0) begin n_err++; $display("FAIL div_min_m1 got hi=%h lo=%h want hi=0 lo=80000000", hi, lo); end
    step(1);
  endtask

  task automatic test_div_by_zero;
    launch(3'b011, 32'h00001234, 32'h0);
    n_cmp++; if ({done, dbz, busy} !== 3'b110) begin n_err++; $display("FAIL dbz_k1 got done,dbz,busy=%b want 110", {done, dbz, busy}); end
    n_cmp++; if (hi !== 32'h00001234 || lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dbz_result got hi=%h lo=%h want hi=00001234 lo=ffffffff", hi, lo); end
    step(1);
    n_cmp++; if ({done, dbz, busy} !== 3'b000) begin n_err++; $display("FAIL dbz_k2 got done,dbz,busy=%b want 000", {done, dbz, busy}); end
  endtask

  task automatic test_noop;
    logic [W-1:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    launch(3'b110, 32'hDEADBEEF, 32'h0);
    n_cmp++; if ({done, busy} !== 2'b00 || hi !== hi0 || lo !== lo0) begin n_err++; $display("FAIL noop got done,busy=%b hi=%h lo=%h want 00 hi=%h lo=%h", {done, busy}, hi, lo, hi0, lo0); end
    step(1);
  endtask

  task automatic test_busy_ignore;
    int n;
    logic [W-1:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    launch(3'b000, 32'd6, 32'd7);
    step(4);
    op = 3'b010; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || hi !== hi0 || lo !== lo0) begin n_err++; $display("FAIL busy_hold got busy=%b hi=%h lo=%h want 1 hi=%h lo=%h", busy, hi, lo, hi0, lo0); end
    wait_done(6, n);
    n_cmp++; if (n !== 34) begin n_err++; $display("FAIL busy_ignore_latency got %0d want 34", n); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h2A) begin n_err++; $display("FAIL busy_ignore_result got hi=%h lo=%h want hi=0 lo=2a", hi, lo); end
    launch(3'b101, 32'h55, 32'h0);
    n_cmp++; if (done !== 1'b1 || lo !== 32'h55 || hi !== 32'h0) begin n_err++; $display("FAIL mtlo_b2b got done=%b hi=%h lo=%h want 1 hi=0 lo=55", done, hi, lo); end
    step(1);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL div_not_started got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_reset_abort;
    int n;
    int dones;
    launch(3'b100, 32'h0000AAAA, 32'h0);
    n_cmp++; if (done !== 1'b1 || hi !== 32'h0000AAAA || lo !== 32'h55) begin n_err++; $display("FAIL mthi got done=%b hi=%h lo=%h want 1 hi=0000aaaa lo=55", done, hi, lo); end
    launch(3'b011, 32'd100, 32'd7);
    step(9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin n_err++; $display("FAIL abort_state got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
    launch(3'b001, 32'd2, 32'd3);
    wait_done(1, n);
    n_cmp++; if (n !== 34 || lo !== 32'd6 || hi !== 32'd0) begin n_err++; $display("FAIL after_abort got lat=%0d hi=%h lo=%h want 34 0 6", n, hi, lo); end
    step(1);
  endtask

  initial begin
    test_reset;
    test_mult;
    test_mult_full;
    test_div;
    test_div_by_zero;
    test_noop;
    test_busy_ignore;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
